led_blink_driver: RTL
=====================

# led_blink_driver

Output-side counterpart to the button debouncer. It takes single-cycle event pulses from core logic and turns each one into a human-visible LED blink of fixed on and off duration. Events that arrive while a blink is in progress are queued in a saturating pending counter and are never merged. It sits between SoC status or event logic and a board LED pin, and uses the same slow-tick prescaling scheme as the button input path (2.5 ms tick at 12 MHz by default).

## Interface
- CLK_DIV, 30000: clk cycles per slow tick (≥1).
- ON_TICKS, 40: slow ticks LED is lit per blink (≥1).
- OFF_TICKS, 40: slow ticks LED is dark after each blink (≥1).
- PEND_W, 4: width of the pending-event counter.

- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- evt  in  1  event pulse; each cycle high counts as one event.
- led  out  1  LED drive, registered, active-high.
- busy  out  1  high while in ON or OFF state.
- pending  out  PEND_W  queued events not yet started.
- overflow  out  1  sticky; an event was dropped due to saturation.

## Operation
- States: IDLE, ON, OFF.
- Prescaler `pre` counts 0..CLK_DIV-1. tick = (pre == CLK_DIV-1). `pre` and the tick counter clear on every state entry, so phase is exact.
- Tick counter counts ticks within the current state. Width is sized to hold max(ON_TICKS, OFF_TICKS).
- IDLE:
  - pending>0 → ON, led=1, pending decremented (dequeue).
  - Otherwise stay in IDLE.
- ON: after ON_TICKS ticks → OFF, led=0.
- OFF: after OFF_TICKS ticks:
  - pending>0 → ON with dequeue.
  - Otherwise → IDLE.
- busy = (state != IDLE), registered together with state.
- Pending update per cycle:
  - Next value = pending + evt − dequeue.
  - Saturates at 2^PEND_W−1.
  - evt and dequeue in the same cycle: net unchanged, including at max; no overflow in that case.
  - evt with pending at max and no dequeue: event dropped, overflow ← 1.
- overflow clears only on rst.
- evt is not sampled while rst is high.
- Reset values: state IDLE, led 0, busy 0, pending 0, overflow 0, pre 0, tick counter 0.
- rst mid-blink aborts immediately and discards all queued events.

## Timing
- evt high in cycle n from IDLE with pending=0:
  - pending=1 in cycle n+1.
  - led=1, busy=1, pending=0 from cycle n+2.
- led high for exactly ON_TICKS·CLK_DIV cycles per blink.
- led low for exactly OFF_TICKS·CLK_DIV cycles after each blink, even when pending>0.
- OFF→ON and OFF→IDLE transitions happen on the edge ending the last OFF cycle.
- Back-to-back blinks: period is (ON_TICKS+OFF_TICKS)·CLK_DIV cycles.
- pending reflects the dequeue in the same cycle led rises.
- rst high in cycle m: all outputs at reset values from cycle m+1.

## Test plan
All scenarios use CLK_DIV=4, ON_TICKS=3, OFF_TICKS=2 (ON lasts 12 cycles, OFF lasts 8), unless stated otherwise.
- Single evt at cycle 10:
  - led high cycles 12–23, low from 24.
  - busy high 12–31, state IDLE at 32.
  - pending: 1 at cycle 11, 0 at cycle 12.
- evt at cycles 10, 11, 12:
  - Three 12-cycle led pulses separated by 8 low cycles; rising edges at 12, 32, 52.
  - pending reads 1, 1, 2 at cycles 11, 12, 13; 0 from cycle 52.
  - overflow stays 0.
- PEND_W=2, evt at cycles 10–14:
  - pending reaches 3.
  - overflow=1 from cycle 15.
  - Exactly 4 blinks, rising at 12, 32, 52, 72.
- PEND_W=2 with pending=3 during OFF, evt asserted in the final OFF cycle:
  - pending stays 3.
  - overflow stays 0.
  - Next ON starts on schedule.
- rst asserted at cycle 16 (mid-ON, pending=2), one cycle:
  - Cycle 17: led 0, busy 0, pending 0, overflow 0.
  - evt at cycle 20 → led high at cycle 22 for 12 cycles.
- evt held high together with rst for 5 cycles, then both low: pending stays 0 and led never rises.

Source files
------------

// File: rtl/led_blink_driver.sv
// Turns single-cycle event pulses into fixed-length LED blinks, queueing
// events that arrive mid-blink in a saturating pending counter.
module led_blink_driver #(
   parameter int unsigned CLK_DIV   = 30000,
   parameter int unsigned ON_TICKS  = 40,
   parameter int unsigned OFF_TICKS = 40,
   parameter int unsigned PEND_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evt,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TCK_W     = $clog2(MAX_TICKS + 1);

   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [TCK_W-1:0]  ON_LAST  = TCK_W'(ON_TICKS - 1);
   localparam logic [TCK_W-1:0]  OFF_LAST = TCK_W'(OFF_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_OFF
   } state_t;

   state_t           state;
   logic [PRE_W-1:0] pre;
   logic [TCK_W-1:0] tcnt;

   logic             tick;
   logic             on_done;
   logic             off_done;
   logic             dequeue;
   logic [PRE_W-1:0] pre_adv;
   logic [TCK_W-1:0] tcnt_adv;

   always_comb begin
      tick     = (pre == PRE_LAST);
      on_done  = (state == ST_ON)  && tick && (tcnt == ON_LAST);
      off_done = (state == ST_OFF) && tick && (tcnt == OFF_LAST);
      // A queued event starts either straight from IDLE or on the edge that ends OFF.
      dequeue  = (pending != '0) && ((state == ST_IDLE) || off_done);
      pre_adv  = tick ? '0 : pre + PRE_W'(1);
      tcnt_adv = tick ? tcnt + TCK_W'(1) : tcnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         led      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
         pre      <= '0;
         tcnt     <= '0;
      end else begin
         // evt together with a dequeue is a net no-op, even when saturated.
         if (evt && !dequeue) begin
            if (pending == PEND_MAX) begin
               overflow <= 1'b1;
            end else begin
               pending <= pending + PEND_W'(1);
            end
         end else if (!evt && dequeue) begin
            pending <= pending - PEND_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (dequeue) begin
                  state <= ST_ON;
                  led   <= 1'b1;
                  busy  <= 1'b1;
                  pre   <= '0;
                  tcnt  <= '0;
               end
            end
            ST_ON: begin
               if (on_done) begin
                  state <= ST_OFF;
                  led   <= 1'b0;
                  pre   <= '0;
                  tcnt  <= '0;
               end else begin
                  pre   <= pre_adv;
                  tcnt  <= tcnt_adv;
               end
            end
            ST_OFF: begin
               if (off_done) begin
                  pre  <= '0;
                  tcnt <= '0;
                  if (dequeue) begin
                     state <= ST_ON;
                     led   <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  pre  <= pre_adv;
                  tcnt <= tcnt_adv;
               end
            end
            default: begin
               state <= ST_IDLE;
               led   <= 1'b0;
               busy  <= 1'b0;
               pre   <= '0;
               tcnt  <= '0;
            end
         endcase
      end
   end

endmodule
